// File: rtl/sr_icache_pkg.sv
// -----------------------------------------------------------------------------
// sr_icache_pkg
// Shared definitions for the schoolRISCV instruction cache: FSM state
// encodings and the default cache geometry. Field widths are derived locally
// in each module from the geometry parameters.
// No ports (package).
// -----------------------------------------------------------------------------
package sr_icache_pkg;

    // Default geometry: 16 lines of 4 words each.
    localparam int IC_SETS_DEFAULT       = 16;
    localparam int IC_LINE_WORDS_DEFAULT = 4;

    // Cache controller state encodings.
    localparam logic [1:0] IC_IDLE   = 2'd0;
    localparam logic [1:0] IC_REFILL = 2'd1;
    localparam logic [1:0] IC_RESP   = 2'd2;

endpackage

// File: rtl/sr_icache_if.sv
// -----------------------------------------------------------------------------
// sr_icache_if
// Bundles the core-side fetch port and the memory-side refill port of the
// instruction cache. Signal names match the schoolRISCV core so the two
// connect wire-for-wire.
//   slave  : the cache's view (takes fetch requests, drives the refill bus)
//   master : the environment's view (core + instruction memory)
// Signals:
//   im_req, imAddr      fetch request pulse and word address
//   imData, im_drdy     fetched instruction and its one-cycle valid pulse
//   flush               invalidate all lines
//   mem_req, mem_addr   refill in progress and current beat word address
//   mem_rdata, mem_ack  beat data and beat acknowledge
// -----------------------------------------------------------------------------
interface sr_icache_if;

    logic        im_req;
    logic [31:0] imAddr;
    logic [31:0] imData;
    logic        im_drdy;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  im_req, imAddr, flush, mem_rdata, mem_ack,
        output imData, im_drdy, mem_req, mem_addr
    );

    modport master (
        output im_req, imAddr, flush, mem_rdata, mem_ack,
        input  imData, im_drdy, mem_req, mem_addr
    );

endinterface

// File: rtl/sr_icache_ram.sv
// -----------------------------------------------------------------------------
// sr_icache_ram
// Data array of the instruction cache: one synchronous write port and one
// asynchronous read port, no reset. Kept separate so it can be replaced by a
// technology RAM macro.
// Ports:
//   clk_i             clock
//   we_i              write enable
//   waddr_i, wdata_i  write address / data
//   raddr_i           read address
//   rdata_o           combinational read data
// -----------------------------------------------------------------------------
module sr_icache_ram #(
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [31:0]              wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sr_icache.sv
// -----------------------------------------------------------------------------
// sr_icache
// Direct-mapped instruction cache for the schoolRISCV core. Hits answer one
// cycle after the request; misses refill the whole line beat by beat from a
// word-wide memory, capture the requested word on the way, and answer once
// the line is complete.
// Ports:
//   clk    clock, all logic on the rising edge
//   rst_n  synchronous active-low reset
//   bus    sr_icache_if.slave: fetch port (im_req/imAddr/imData/im_drdy/flush)
//          and refill port (mem_req/mem_addr/mem_rdata/mem_ack)
// -----------------------------------------------------------------------------
module sr_icache
    import sr_icache_pkg::*;
#(
    parameter int SETS       = IC_SETS_DEFAULT,
    parameter int LINE_WORDS = IC_LINE_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    sr_icache_if.slave  bus
);

    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(SETS);
    localparam int TW = 32 - OW - IW;

    logic [OW-1:0]   reqOff;
    logic [IW-1:0]   reqIdx;
    logic [TW-1:0]   reqTag;

    logic [1:0]      state_q, state_d;
    logic [SETS-1:0] valid_q, valid_d;
    logic [TW-1:0]   tags_q [SETS];
    logic [TW-1:0]   tagL_q, tagL_d;
    logic [IW-1:0]   idxL_q, idxL_d;
    logic [OW-1:0]   offL_q, offL_d;
    logic [OW-1:0]   beat_q, beat_d;
    logic            flushSeen_q, flushSeen_d;
    logic [31:0]     imData_q, imData_d;
    logic            drdy_q, drdy_d;

    logic            hit;
    logic            ackBeat;
    logic            lastAck;
    logic [31:0]     ramRdata;

    assign reqOff = bus.imAddr[OW-1:0];
    assign reqIdx = bus.imAddr[OW+IW-1:OW];
    assign reqTag = bus.imAddr[31:OW+IW];

    assign hit     = (state_q == IC_IDLE) && valid_q[reqIdx] && (tags_q[reqIdx] == reqTag);
    assign ackBeat = (state_q == IC_REFILL) && bus.mem_ack;
    assign lastAck = ackBeat && (beat_q == {OW{1'b1}});

    // Read side always looks up the incoming request; write side follows
    // the refill beat counter.
    sr_icache_ram #(
        .DEPTH (SETS * LINE_WORDS)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ackBeat),
        .waddr_i ({idxL_q, beat_q}),
        .wdata_i (bus.mem_rdata),
        .raddr_i ({reqIdx, reqOff}),
        .rdata_o (ramRdata)
    );

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tagL_d      = tagL_q;
        idxL_d      = idxL_q;
        offL_d      = offL_q;
        beat_d      = beat_q;
        flushSeen_d = flushSeen_q;
        imData_d    = imData_q;
        drdy_d      = 1'b0;

        // A flush wipes every line; a same-cycle lookup still sees the old bits.
        if (bus.flush) begin
            valid_d = '0;
        end

        case (state_q)
            IC_IDLE: begin
                if (bus.im_req) begin
                    if (hit) begin
                        imData_d = ramRdata;
                        drdy_d   = 1'b1;
                    end else begin
                        tagL_d      = reqTag;
                        idxL_d      = reqIdx;
                        offL_d      = reqOff;
                        beat_d      = '0;
                        flushSeen_d = 1'b0;
                        // The line is overwritten in place, so it must not
                        // hit under its old tag if the refill is abandoned.
                        valid_d[reqIdx] = 1'b0;
                        state_d     = IC_REFILL;
                    end
                end
            end
            IC_REFILL: begin
                if (bus.flush) begin
                    flushSeen_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    if (beat_q == offL_q) begin
                        imData_d = bus.mem_rdata;
                    end
                    beat_d = beat_q + 1'b1;
                    if (lastAck) begin
                        // A flush anywhere in the refill, including this
                        // cycle, leaves the new line invalid.
                        if (!flushSeen_q && !bus.flush) begin
                            valid_d[idxL_q] = 1'b1;
                        end
                        drdy_d  = 1'b1;
                        state_d = IC_RESP;
                    end
                end
            end
            IC_RESP: begin
                state_d = IC_IDLE;
            end
            default: begin
                state_d = IC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IC_IDLE;
            valid_q     <= '0;
            tagL_q      <= '0;
            idxL_q      <= '0;
            offL_q      <= '0;
            beat_q      <= '0;
            flushSeen_q <= 1'b0;
            imData_q    <= '0;
            drdy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            tagL_q      <= tagL_d;
            idxL_q      <= idxL_d;
            offL_q      <= offL_d;
            beat_q      <= beat_d;
            flushSeen_q <= flushSeen_d;
            imData_q    <= imData_d;
            drdy_q      <= drdy_d;
        end
    end

    // Tag array is not reset; the valid vector guards it.
    always_ff @(posedge clk) begin
        if (lastAck) begin
            tags_q[idxL_q] <= tagL_q;
        end
    end

    assign bus.imData   = imData_q;
    assign bus.im_drdy  = drdy_q;
    assign bus.mem_req  = (state_q == IC_REFILL);
    assign bus.mem_addr = (state_q == IC_REFILL) ? {tagL_q, idxL_q, beat_q} : 32'd0;

endmodule
